// File: rtl/pa_idu_wb_pkg.sv
// Shared definitions for the IDU GPR writeback arbiter: source-select
// encoding, LSU buffer depth, GPR count and the buffered-entry type.
package pa_idu_wb_pkg;

  localparam int LSU_BUF_DEPTH = 2;
  localparam int GPR_NUM       = 32;
  localparam int IDX_W         = $clog2(GPR_NUM);
  localparam int DATA_W        = 32;
  localparam int BUF_PTR_W     = $clog2(LSU_BUF_DEPTH);
  localparam int BUF_CNT_W     = $clog2(LSU_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'b00,
    WB_SEL_ALU  = 2'b01,
    WB_SEL_LSU  = 2'b10,
    WB_SEL_DIV  = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

endpackage

// File: rtl/pa_idu_wb_lsu_buf.sv
// Small in-order FIFO holding load writebacks that lost arbitration.
// Head is presented combinationally so it can be granted in the same cycle.
module pa_idu_wb_lsu_buf
  import pa_idu_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 push,
  input  wb_ent_t              push_ent,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output wb_ent_t              head,
  output logic [BUF_CNT_W-1:0] cnt
);

  wb_ent_t                  ent [LSU_BUF_DEPTH];
  logic [LSU_BUF_DEPTH-1:0] ent_vld;
  logic [BUF_PTR_W-1:0]     wptr;
  logic [BUF_PTR_W-1:0]     rptr;
  logic [BUF_CNT_W-1:0]     cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      ent_vld <= '0;
    end else begin
      // When full, wptr == rptr: a same-cycle pop/push reuses the slot, and
      // the later set of the valid bit wins over the clear.
      if (pop)  ent_vld[rptr] <= 1'b0;
      if (push) ent_vld[wptr] <= 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      cnt_q <= cnt_q + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
    end
  end

  // Payload is not reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) ent[wptr] <= push_ent;
  end

  assign head  = ent[rptr];
  assign empty = ~ent_vld[rptr];
  assign full  = (cnt_q == BUF_CNT_W'(LSU_BUF_DEPTH));
  assign cnt   = cnt_q;

endmodule

// File: rtl/pa_idu_gpr_wb_arb.sv
// GPR writeback arbiter: ALU > buffered load > direct load > DIV, one write
// per cycle, combinational output. DIV port enabled by PA_IDU_WB_DIV_PORT_EN.
module pa_idu_gpr_wb_arb
  import pa_idu_wb_pkg::*;
(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 alu_wb_vld,
  input  logic [IDX_W-1:0]     alu_wb_idx,
  input  logic [DATA_W-1:0]    alu_wb_data,
  input  logic                 lsu_wb_vld,
  input  logic [IDX_W-1:0]     lsu_wb_idx,
  input  logic [DATA_W-1:0]    lsu_wb_data,
  output logic                 lsu_wb_rdy,
  input  logic                 div_wb_vld,
  input  logic [IDX_W-1:0]     div_wb_idx,
  input  logic [DATA_W-1:0]    div_wb_data,
  output logic                 div_wb_rdy,
  output logic [GPR_NUM-1:0]   reg_write_en,
  output logic [DATA_W-1:0]    reg_write_data,
  output logic                 wb_flsu_vld,
  output logic [BUF_CNT_W-1:0] lsu_buf_cnt
);

  wb_ent_t              buf_head;
  wb_ent_t              lsu_ent;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 buf_push;
  logic                 buf_pop;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic                 buf_vld;
  logic                 buf_full_eff;
  logic                 lsu_direct;
  logic                 div_grant;
  wb_sel_e              wb_sel;
  logic [IDX_W-1:0]     wr_idx;

  assign lsu_ent = '{idx: lsu_wb_idx, data: lsu_wb_data};

  pa_idu_wb_lsu_buf u_lsu_buf (
    .clk      (forever_cpuclk),
    .rst_b    (cpurst_b),
    .push     (buf_push),
    .push_ent (lsu_ent),
    .pop      (buf_pop),
    .full     (buf_full),
    .empty    (buf_empty),
    .head     (buf_head),
    .cnt      (buf_cnt)
  );

  // While reset is held the buffer is treated as empty, so stale entries can
  // never be written out in the reset cycle itself.
  assign buf_vld      = ~buf_empty & cpurst_b;
  assign buf_full_eff = buf_full & cpurst_b;

  assign buf_pop    = buf_vld & ~alu_wb_vld;
  assign lsu_direct = lsu_wb_vld & ~alu_wb_vld & ~buf_vld;
  assign lsu_wb_rdy = ~buf_full_eff | buf_pop;
  assign buf_push   = lsu_wb_vld & lsu_wb_rdy & ~lsu_direct;
  assign lsu_buf_cnt = cpurst_b ? buf_cnt : '0;

`ifdef PA_IDU_WB_DIV_PORT_EN
  assign div_wb_rdy = ~alu_wb_vld & ~buf_vld & ~lsu_wb_vld;
  assign div_grant  = div_wb_vld & div_wb_rdy;
`else
  logic unused_div;
  assign unused_div = ^{div_wb_vld, div_wb_idx, div_wb_data};
  assign div_wb_rdy = 1'b0;
  assign div_grant  = 1'b0;
`endif

  always_comb begin
    wb_sel         = WB_SEL_NONE;
    wr_idx         = alu_wb_idx;
    reg_write_data = alu_wb_data;
    if (alu_wb_vld) begin
      wb_sel = WB_SEL_ALU;
    end else if (buf_pop) begin
      wb_sel         = WB_SEL_LSU;
      wr_idx         = buf_head.idx;
      reg_write_data = buf_head.data;
    end else if (lsu_direct) begin
      wb_sel         = WB_SEL_LSU;
      wr_idx         = lsu_wb_idx;
      reg_write_data = lsu_wb_data;
`ifdef PA_IDU_WB_DIV_PORT_EN
    end else if (div_grant) begin
      wb_sel         = WB_SEL_DIV;
      wr_idx         = div_wb_idx;
      reg_write_data = div_wb_data;
`endif
    end
  end

  // x0 writes still complete their handshake but never raise an enable.
  always_comb begin
    reg_write_en = '0;
    if (wb_sel != WB_SEL_NONE) reg_write_en[wr_idx] = 1'b1;
    reg_write_en[0] = 1'b0;
  end

  assign wb_flsu_vld = (wb_sel == WB_SEL_LSU) && (wr_idx != '0);

endmodule

// File: tb/tb_pa_idu_gpr_wb_arb.sv
// Directed + random bench for pa_idu_gpr_wb_arb against a queue-based model.
module tb_pa_idu_gpr_wb_arb;

`ifdef PA_IDU_WB_DIV_PORT_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct { logic [4:0] idx; logic [31:0] data; } ld_t;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        alu_wb_vld, lsu_wb_vld, div_wb_vld;
  logic [4:0]  alu_wb_idx, lsu_wb_idx, div_wb_idx;
  logic [31:0] alu_wb_data, lsu_wb_data, div_wb_data;
  logic        lsu_wb_rdy, div_wb_rdy, wb_flsu_vld;
  logic [31:0] reg_write_en, reg_write_data;
  logic [1:0]  lsu_buf_cnt;

  int errs = 0;
  int checks = 0;
  ld_t q[$];
  bit  m_pop, m_push;
  ld_t m_ent;

  always #5 forever_cpuclk = ~forever_cpuclk;

  pa_idu_gpr_wb_arb dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .alu_wb_vld     (alu_wb_vld),
    .alu_wb_idx     (alu_wb_idx),
    .alu_wb_data    (alu_wb_data),
    .lsu_wb_vld     (lsu_wb_vld),
    .lsu_wb_idx     (lsu_wb_idx),
    .lsu_wb_data    (lsu_wb_data),
    .lsu_wb_rdy     (lsu_wb_rdy),
    .div_wb_vld     (div_wb_vld),
    .div_wb_idx     (div_wb_idx),
    .div_wb_data    (div_wb_data),
    .div_wb_rdy     (div_wb_rdy),
    .reg_write_en   (reg_write_en),
    .reg_write_data (reg_write_data),
    .wb_flsu_vld    (wb_flsu_vld),
    .lsu_buf_cnt    (lsu_buf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_wb_vld = 0; lsu_wb_vld = 0; div_wb_vld = 0;
  endtask

  task automatic drv_alu(input logic [4:0] i, input logic [31:0] d);
    alu_wb_vld = 1; alu_wb_idx = i; alu_wb_data = d;
  endtask

  task automatic drv_lsu(input logic [4:0] i, input logic [31:0] d);
    lsu_wb_vld = 1; lsu_wb_idx = i; lsu_wb_data = d;
  endtask

  task automatic drv_div(input logic [4:0] i, input logic [31:0] d);
    div_wb_vld = 1; div_wb_idx = i; div_wb_data = d;
  endtask

  // Settle, derive the expected cycle from the model and compare everything.
  task automatic eval(input string tag);
    bit g, lsu_src, direct, rdy_e;
    logic [4:0]  idx_e;
    logic [31:0] data_e, en_e;
    #2;
    g = 0; lsu_src = 0; direct = 0;
    idx_e = alu_wb_idx; data_e = alu_wb_data;
    m_pop = (q.size() > 0) && !alu_wb_vld;
    if (alu_wb_vld) g = 1;
    else if (m_pop) begin
      g = 1; lsu_src = 1; idx_e = q[0].idx; data_e = q[0].data;
    end else if (lsu_wb_vld) begin
      g = 1; lsu_src = 1; direct = 1; idx_e = lsu_wb_idx; data_e = lsu_wb_data;
    end else if (DIV_EN && div_wb_vld) begin
      g = 1; idx_e = div_wb_idx; data_e = div_wb_data;
    end
    en_e  = (g && idx_e != 0) ? (32'd1 << idx_e) : 32'd0;
    rdy_e = (q.size() < 2) || m_pop;
    m_push = lsu_wb_vld && rdy_e && !direct;
    m_ent  = '{idx: lsu_wb_idx, data: lsu_wb_data};
    chk({tag, ".en"},   reg_write_en, en_e);
    chk({tag, ".data"}, reg_write_data, data_e);
    chk({tag, ".flsu"}, {31'd0, wb_flsu_vld}, {31'd0, lsu_src && idx_e != 0});
    chk({tag, ".lrdy"}, {31'd0, lsu_wb_rdy}, {31'd0, rdy_e});
    chk({tag, ".drdy"}, {31'd0, div_wb_rdy},
        {31'd0, DIV_EN && !alu_wb_vld && q.size() == 0 && !lsu_wb_vld});
    chk({tag, ".cnt"},  {30'd0, lsu_buf_cnt}, q.size());
  endtask

  task automatic tick();
    @(posedge forever_cpuclk); #1;
    if (m_pop)  void'(q.pop_front());
    if (m_push) q.push_back(m_ent);
  endtask

  task automatic step(input string tag);
    eval(tag);
    tick();
  endtask

  initial begin
    cpurst_b = 0; idle();
    alu_wb_idx = 0; alu_wb_data = 0; lsu_wb_idx = 0; lsu_wb_data = 0;
    div_wb_idx = 0; div_wb_data = 0;
    @(posedge forever_cpuclk); #1;
    @(posedge forever_cpuclk); #1;
    #2;
    chk("rst.cnt", {30'd0, lsu_buf_cnt}, 32'd0);
    chk("rst.lrdy", {31'd0, lsu_wb_rdy}, 32'd1);
    chk("rst.en", reg_write_en, 32'd0);
    cpurst_b = 1;
    @(posedge forever_cpuclk); #1;

    // ALU and LSU together: ALU now, load next cycle.
    drv_alu(5'd5, 32'h11); drv_lsu(5'd6, 32'h22);
    eval("t026a");
    chk("t026a.en_k", reg_write_en, 32'h20);
    tick();
    idle();
    eval("t026b");
    chk("t026b.en_k", reg_write_en, 32'h40);
    chk("t026b.data_k", reg_write_data, 32'h22);
    chk("t026b.flsu_k", {31'd0, wb_flsu_vld}, 32'd1);
    tick();

    // ALU busy 4 cycles, 3 loads offered; third stalls until ALU stops.
    drv_alu(5'd8, 32'hA0); drv_lsu(5'd1, 32'h101); step("t027c0");
    drv_alu(5'd9, 32'hA1); drv_lsu(5'd2, 32'h102); step("t027c1");
    drv_alu(5'd10, 32'hA2); drv_lsu(5'd3, 32'h103);
    eval("t027c2");
    chk("t027c2.cnt_k", {30'd0, lsu_buf_cnt}, 32'd2);
    chk("t027c2.rdy_k", {31'd0, lsu_wb_rdy}, 32'd0);
    tick();
    drv_alu(5'd11, 32'hA3); step("t027c3");
    alu_wb_vld = 0;
    eval("t028");
    chk("t028.en_k", reg_write_en, 32'h2);
    chk("t028.rdy_k", {31'd0, lsu_wb_rdy}, 32'd1);
    tick();
    lsu_wb_vld = 0;
    chk("t028.cnt_k", {30'd0, lsu_buf_cnt}, 32'd2);
    eval("t027w2");
    chk("t027w2.en_k", reg_write_en, 32'h4);
    tick();
    eval("t027w3");
    chk("t027w3.en_k", reg_write_en, 32'h8);
    tick();

    // DIV waits for the LSU path to drain.
    drv_alu(5'd10, 32'hB0); drv_lsu(5'd9, 32'h99); step("t029a");
    alu_wb_vld = 0; drv_div(5'd7, 32'h77); drv_lsu(5'd12, 32'hCC);
    eval("t029b");
    chk("t029b.drdy_k", {31'd0, div_wb_rdy}, 32'd0);
    tick();
    lsu_wb_vld = 0;
    eval("t029c");
    chk("t029c.drdy_k", {31'd0, div_wb_rdy}, 32'd0);
    tick();
    eval("t029d");
    chk("t029d.en_k", reg_write_en, DIV_EN ? 32'h80 : 32'h0);
    chk("t029d.flsu_k", {31'd0, wb_flsu_vld}, 32'd0);
    tick();
    idle();

    // x0 load: consumed directly, no enable, not buffered.
    drv_lsu(5'd0, 32'hFF);
    eval("t030");
    chk("t030.en_k", reg_write_en, 32'd0);
    chk("t030.rdy_k", {31'd0, lsu_wb_rdy}, 32'd1);
    tick();
    idle();
    chk("t030.cnt_k", {30'd0, lsu_buf_cnt}, 32'd0);

    // Fill the buffer, then reset: entries are discarded, never written.
    drv_alu(5'd4, 32'h1); drv_lsu(5'd13, 32'hD1); step("t031f0");
    drv_alu(5'd4, 32'h2); drv_lsu(5'd14, 32'hD2); step("t031f1");
    idle();
    cpurst_b = 0;
    #2;
    chk("t031r.cnt", {30'd0, lsu_buf_cnt}, 32'd0);
    chk("t031r.lrdy", {31'd0, lsu_wb_rdy}, 32'd1);
    chk("t031r.en", reg_write_en, 32'd0);
    @(posedge forever_cpuclk); #1;
    q.delete();
    cpurst_b = 1;
    eval("t031p");
    chk("t031p.en_k", reg_write_en, 32'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      alu_wb_vld  = ($urandom_range(0, 99) < 40);
      alu_wb_idx  = 5'($urandom_range(0, 31));
      alu_wb_data = $urandom;
      lsu_wb_vld  = ($urandom_range(0, 99) < 55);
      lsu_wb_idx  = 5'($urandom_range(0, 31));
      lsu_wb_data = $urandom;
      div_wb_vld  = ($urandom_range(0, 99) < 30);
      div_wb_idx  = 5'($urandom_range(0, 31));
      div_wb_data = $urandom;
      step("rnd");
    end
    idle();
    for (int n = 0; n < 4; n++) step("drain");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pa_idu_gpr_wb_arb.md
PA_IDU_GPR_WB_ARB -- requirements
Module: pa_idu_gpr_wb_arb

Interface
REQ-001 SHALL have one clock `forever_cpuclk` and one reset `cpurst_b`; the reset is synchronous and active-low.
REQ-002 SHALL declare the ports in this order (name, direction, width, meaning):
- forever_cpuclk  in  1  core clock.
- cpurst_b  in  1  synchronous active-low reset.
- alu_wb_vld  in  1  ALU writeback valid; has no ready signal and is never stalled.
- alu_wb_idx  in  5  ALU destination GPR.
- alu_wb_data  in  32  ALU result.
- lsu_wb_vld  in  1  load writeback valid.
- lsu_wb_idx  in  5  load destination GPR.
- lsu_wb_data  in  32  load data.
- lsu_wb_rdy  out  1  load writeback accepted.
- div_wb_vld  in  1  divider writeback valid.
- div_wb_idx  in  5  divider destination GPR.
- div_wb_data  in  32  divider result.
- div_wb_rdy  out  1  divider writeback accepted.
- reg_write_en  out  32  one-hot per-GPR write enable; bit 0 is always 0.
- reg_write_data  out  32  shared GPR write data.
- wb_flsu_vld  out  1  current write comes from the LSU path (drives rtu_idu_fgpr_wb_flsu_vld).
- lsu_buf_cnt  out  2  LSU buffer occupancy, 0..2.

Function
REQ-003 A handshake SHALL complete when vld and rdy are both 1 in the same cycle.
REQ-004 At most one GPR write SHALL be granted per cycle.
REQ-005 Grant priority SHALL be: ALU, then LSU buffer head, then direct LSU input, then DIV.
REQ-006 The output path SHALL be combinational; a granted source appears on reg_write_en/reg_write_data in the same cycle.
REQ-007 Load data SHALL be written to the GPRs in LSU acceptance order.
REQ-008 Direct LSU input SHALL be granted only when the buffer is empty and alu_wb_vld=0.
REQ-009 An accepted LSU writeback that is not granted directly SHALL be enqueued in a 2-entry FIFO.
REQ-010 lsu_wb_rdy SHALL equal (buffer not full) OR (the buffer head is granted this cycle), so an enqueue and a dequeue can happen in the same cycle.
REQ-011 On a simultaneous enqueue and dequeue, the count SHALL be unchanged and the pointers SHALL advance mod 2.
REQ-012 div_wb_rdy SHALL be 1 only when no ALU, buffered LSU or LSU input is valid in that cycle.
REQ-013 A write whose index is 0 SHALL be consumed (handshake completes) and SHALL produce an all-zero reg_write_en.
REQ-014 wb_flsu_vld SHALL be 1 exactly when an LSU-sourced write with a nonzero index is granted.
REQ-015 When nothing is granted, reg_write_en SHALL be 0; reg_write_data SHALL then be the ALU data (don't-care to consumers).
REQ-016 Flush SHALL NOT affect this block; buffered loads are architecturally committed.

Reset
REQ-017 While cpurst_b=0 at a clock edge, the block SHALL clear the buffer count and both pointers and invalidate both entries.
REQ-018 Buffer data SHALL NOT be reset.
REQ-019 During reset, lsu_buf_cnt=0 and lsu_wb_rdy=1.
REQ-020 A reset mid-operation SHALL discard buffered entries; the upstream pipeline is reset together with this block.

Configuration
REQ-021 Macro `PA_IDU_WB_DIV_PORT_EN`, when defined, SHALL enable the DIV port as specified above.
REQ-022 When `PA_IDU_WB_DIV_PORT_EN` is undefined:
- div_wb_rdy SHALL be tied 0;
- the div_* inputs SHALL be ignored;
- no DIV arbitration logic SHALL be synthesized.

Structure
REQ-023 A shared package `pa_idu_wb_pkg` SHALL hold:
- the 2-bit source-select encoding (NONE=00, ALU=01, LSU=10, DIV=11);
- the constant LSU_BUF_DEPTH=2;
- the constant GPR_NUM=32.
REQ-024 The LSU FIFO SHALL be a separate sub-module `pa_idu_wb_lsu_buf` with push/pop/full/empty/head outputs.
REQ-025 Arbitration and the 5-to-32 decode SHALL live in the top module.

Verification
REQ-026 ALU idx=5 data=0x11 and LSU idx=6 data=0x22 in cycle N:
- cycle N: reg_write_en=0x20, data=0x11;
- cycle N+1: reg_write_en=0x40, data=0x22, wb_flsu_vld=1.
REQ-027 ALU valid for 4 cycles while LSU offers 3 loads (idx 1, 2, 3):
- lsu_buf_cnt reaches 2;
- lsu_wb_rdy=0 on the third offer;
- after the ALU stops, writes occur in order 1, 2, 3.
REQ-028 Buffer full, no ALU, new LSU offered: the head is written, the new load is accepted the same cycle, and lsu_buf_cnt stays 2.
REQ-029 DIV idx=7 valid together with LSU valid:
- div_wb_rdy=0 until the LSU path drains;
- then reg_write_en=0x80, wb_flsu_vld=0.
REQ-030 LSU idx=0 data=0xFF with the buffer empty: handshake completes, reg_write_en=0, wb_flsu_vld=0.
REQ-031 Reset asserted with lsu_buf_cnt=2: next cycle lsu_buf_cnt=0, and no write of the buffered data occurs.
